// File: rtl/sdio_txrx_seq_if.sv
// Engine-side bundle between the transfer sequencer (master) and the SDIO
// command/data engines (slave).
interface sdio_txrx_seq_if;
    logic        cmd_start;
    logic [5:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic [2:0]  cmd_rsp_type;
    logic        cmd_eot;
    logic        cmd_err;
    logic        start_read;
    logic        start_write;
    logic        data_start;
    logic        data_last;
    logic        data_eot;
    logic        data_err;
    logic        data_abort;

    modport master (
        output cmd_start,
        output cmd_op,
        output cmd_arg,
        output cmd_rsp_type,
        output data_start,
        output data_abort,
        input  cmd_eot,
        input  cmd_err,
        input  start_read,
        input  start_write,
        input  data_last,
        input  data_eot,
        input  data_err
    );

    modport slave (
        input  cmd_start,
        input  cmd_op,
        input  cmd_arg,
        input  cmd_rsp_type,
        input  data_start,
        input  data_abort,
        output cmd_eot,
        output cmd_err,
        output start_read,
        output start_write,
        output data_last,
        output data_eot,
        output data_err
    );
endinterface

// File: rtl/sdio_txrx_seq.sv
// SDIO TX/RX transfer sequencer: user command, data-start gating, auto CMD12, abort and EOT.
// Optional inactivity timeout enabled by defining SDIO_SEQ_TIMEOUT_EN.
module sdio_txrx_seq #(
    parameter int unsigned BLOCK_NUM_W = 8,
    parameter int unsigned TIMEOUT_W   = 16
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   clr_stat_i,
    input  logic                   cmd_start_i,
    input  logic [5:0]             cmd_op_i,
    input  logic [31:0]            cmd_arg_i,
    input  logic [2:0]             cmd_rsp_type_i,
    input  logic                   data_en_i,
    input  logic                   data_rwn_i,
    input  logic [BLOCK_NUM_W-1:0] data_block_num_i,
    input  logic                   auto_stop_en_i,
    input  logic [TIMEOUT_W-1:0]   timeout_i,
    output logic                   busy_o,
    output logic                   eot_o,
    output logic [3:0]             status_o,
    sdio_txrx_seq_if.master        eng_io
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StRun,
        StStop,
        StWaitStop,
        StDone
    } state_e;

    localparam logic [5:0] StopOp  = 6'd12;
    localparam logic [2:0] StopRsp = 3'd1;

    state_e      state_q;
    logic        cmd_start_q;
    logic [5:0]  cmd_op_q;
    logic [31:0] cmd_arg_q;
    logic [2:0]  cmd_rsp_q;
    logic        data_en_q;
    logic        data_rwn_q;
    logic        multi_stop_q;
    logic        cmd_done_q;
    logic        data_done_q;
    logic        data_started_q;
    logic        last_q;
    logic        stop_done_q;
    logic        busy_q;
    logic        eot_q;
    logic        abort_q;
    logic [3:0]  status_q;

    logic       active;
    logic       in_run;
    logic       in_wait;
    logic       data_trig;
    logic       data_start_w;
    logic       cmd_done_w;
    logic       data_done_w;
    logic       last_w;
    logic       stop_done_w;
    logic       cmd_fail;
    logic       stop_fail;
    logic       data_fail;
    logic       tmo_hit;
    logic [3:0] status_set;

    assign in_run  = (state_q == StRun);
    assign in_wait = (state_q == StWaitStop);
    assign active  = in_run | in_wait;

    // Data start is combinational from the command engine triggers, one pulse per transaction.
    assign data_trig    = data_rwn_q ? eng_io.start_read : eng_io.start_write;
    assign data_start_w = active & data_en_q & ~data_started_q & data_trig;

    // Flags including this cycle's events so exits happen without an extra cycle.
    assign cmd_done_w  = cmd_done_q | eng_io.cmd_eot;
    assign data_done_w = data_done_q | eng_io.data_eot;
    assign last_w      = last_q | eng_io.data_last;
    assign stop_done_w = stop_done_q | eng_io.cmd_eot;

    assign cmd_fail  = in_run & eng_io.cmd_eot & eng_io.cmd_err;
    assign stop_fail = in_wait & eng_io.cmd_eot & eng_io.cmd_err;
    assign data_fail = active & eng_io.data_eot & eng_io.data_err;

`ifdef SDIO_SEQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt_q;
    logic                 tmo_kick;

    assign tmo_kick = eng_io.cmd_eot | eng_io.data_eot | eng_io.data_last |
                      eng_io.start_read | eng_io.start_write;
    assign tmo_hit  = active & ~tmo_kick & (timeout_i != '0) & (tmo_cnt_q == timeout_i);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tmo_cnt_q <= '0;
        end else if (!active || tmo_kick) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^timeout_i;
    assign tmo_hit        = 1'b0;
`endif

    assign status_set = {tmo_hit, data_fail, stop_fail, cmd_fail};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q        <= StIdle;
            cmd_start_q    <= 1'b0;
            cmd_op_q       <= '0;
            cmd_arg_q      <= '0;
            cmd_rsp_q      <= '0;
            data_en_q      <= 1'b0;
            data_rwn_q     <= 1'b0;
            multi_stop_q   <= 1'b0;
            cmd_done_q     <= 1'b0;
            data_done_q    <= 1'b0;
            data_started_q <= 1'b0;
            last_q         <= 1'b0;
            stop_done_q    <= 1'b0;
            busy_q         <= 1'b0;
            eot_q          <= 1'b0;
            abort_q        <= 1'b0;
            status_q       <= '0;
        end else begin
            cmd_start_q <= 1'b0;
            eot_q       <= 1'b0;
            abort_q     <= 1'b0;
            // A set in the same cycle as a clear wins.
            status_q    <= (clr_stat_i ? 4'b0000 : status_q) | status_set;

            unique case (state_q)
                StIdle: begin
                    if (cmd_start_i) begin
                        cmd_op_q       <= cmd_op_i;
                        cmd_arg_q      <= cmd_arg_i;
                        cmd_rsp_q      <= cmd_rsp_type_i;
                        data_en_q      <= data_en_i;
                        data_rwn_q     <= data_rwn_i;
                        multi_stop_q   <= data_en_i & auto_stop_en_i & (|data_block_num_i);
                        cmd_done_q     <= 1'b0;
                        data_done_q    <= 1'b0;
                        data_started_q <= 1'b0;
                        last_q         <= 1'b0;
                        stop_done_q    <= 1'b0;
                        cmd_start_q    <= 1'b1;
                        busy_q         <= 1'b1;
                        state_q        <= StIssue;
                    end
                end

                StIssue: begin
                    state_q <= StRun;
                end

                StRun: begin
                    if (eng_io.cmd_eot) cmd_done_q <= 1'b1;
                    if (eng_io.data_eot) data_done_q <= 1'b1;
                    if (data_start_w) data_started_q <= 1'b1;
                    if (multi_stop_q && eng_io.data_last) last_q <= 1'b1;

                    if (cmd_fail) begin
                        abort_q <= data_started_q | data_start_w;
                        eot_q   <= 1'b1;
                        state_q <= StDone;
                    end else if (data_fail) begin
                        eot_q   <= 1'b1;
                        state_q <= StDone;
                    end else if (tmo_hit) begin
                        abort_q <= 1'b1;
                        eot_q   <= 1'b1;
                        state_q <= StDone;
                    end else if (multi_stop_q && last_w && cmd_done_w) begin
                        // Stop is only issued once the user command has completed.
                        cmd_start_q <= 1'b1;
                        cmd_op_q    <= StopOp;
                        cmd_arg_q   <= '0;
                        cmd_rsp_q   <= StopRsp;
                        state_q     <= StStop;
                    end else if (cmd_done_w && (!data_en_q || data_done_w)) begin
                        eot_q   <= 1'b1;
                        state_q <= StDone;
                    end
                end

                StStop: begin
                    state_q <= StWaitStop;
                end

                StWaitStop: begin
                    if (eng_io.cmd_eot) stop_done_q <= 1'b1;
                    if (eng_io.data_eot) data_done_q <= 1'b1;
                    if (data_start_w) data_started_q <= 1'b1;

                    if (data_fail) begin
                        eot_q   <= 1'b1;
                        state_q <= StDone;
                    end else if (tmo_hit) begin
                        abort_q <= 1'b1;
                        eot_q   <= 1'b1;
                        state_q <= StDone;
                    end else if (stop_done_w && data_done_w) begin
                        eot_q   <= 1'b1;
                        state_q <= StDone;
                    end
                end

                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign eng_io.cmd_start    = cmd_start_q;
    assign eng_io.cmd_op       = cmd_op_q;
    assign eng_io.cmd_arg      = cmd_arg_q;
    assign eng_io.cmd_rsp_type = cmd_rsp_q;
    assign eng_io.data_start   = data_start_w;
    assign eng_io.data_abort   = abort_q;

    assign busy_o   = busy_q;
    assign eot_o    = eot_q;
    assign status_o = status_q;

endmodule

// File: tb/tb_sdio_txrx_seq.sv
// Table-driven bench for sdio_txrx_seq: per-cycle stimulus rows with hand-computed outputs,
// plus a hand-written mid-transaction reset sequence.
module tb_sdio_txrx_seq;

    localparam int unsigned BLOCK_NUM_W = 8;
    localparam int unsigned TIMEOUT_W   = 16;

    localparam logic [8:0] EV_CS    = 9'h100;
    localparam logic [8:0] EV_CEOT  = 9'h080;
    localparam logic [8:0] EV_CERR  = 9'h040;
    localparam logic [8:0] EV_SRD   = 9'h020;
    localparam logic [8:0] EV_SWR   = 9'h010;
    localparam logic [8:0] EV_DLAST = 9'h008;
    localparam logic [8:0] EV_DEOT  = 9'h004;
    localparam logic [8:0] EV_DERR  = 9'h002;
    localparam logic [8:0] EV_CLR   = 9'h001;

    localparam logic [4:0] O_CS  = 5'h10;
    localparam logic [4:0] O_DS  = 5'h08;
    localparam logic [4:0] O_AB  = 5'h04;
    localparam logic [4:0] O_BSY = 5'h02;
    localparam logic [4:0] O_EOT = 5'h01;

    typedef struct {
        int          cfg;
        int          reps;
        logic [8:0]  ev;
        logic [4:0]  eo;
        logic [5:0]  eop;
        logic [31:0] earg;
        logic [2:0]  ersp;
        logic [3:0]  est;
    } vec_t;

    logic                   clk_i = 1'b0;
    logic                   rstn_i;
    logic                   clr_stat_i;
    logic                   cmd_start_i;
    logic [5:0]             cmd_op_i;
    logic [31:0]            cmd_arg_i;
    logic [2:0]             cmd_rsp_type_i;
    logic                   data_en_i;
    logic                   data_rwn_i;
    logic [BLOCK_NUM_W-1:0] data_block_num_i;
    logic                   auto_stop_en_i;
    logic [TIMEOUT_W-1:0]   timeout_i;
    logic                   busy_o;
    logic                   eot_o;
    logic [3:0]             status_o;

    sdio_txrx_seq_if eng_if ();

    sdio_txrx_seq #(
        .BLOCK_NUM_W (BLOCK_NUM_W),
        .TIMEOUT_W   (TIMEOUT_W)
    ) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .clr_stat_i       (clr_stat_i),
        .cmd_start_i      (cmd_start_i),
        .cmd_op_i         (cmd_op_i),
        .cmd_arg_i        (cmd_arg_i),
        .cmd_rsp_type_i   (cmd_rsp_type_i),
        .data_en_i        (data_en_i),
        .data_rwn_i       (data_rwn_i),
        .data_block_num_i (data_block_num_i),
        .auto_stop_en_i   (auto_stop_en_i),
        .timeout_i        (timeout_i),
        .busy_o           (busy_o),
        .eot_o            (eot_o),
        .status_o         (status_o),
        .eng_io           (eng_if)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [5:0]  cfg_op   [4];
    logic [31:0] cfg_arg  [4];
    logic [2:0]  cfg_rsp  [4];
    logic        cfg_den  [4];
    logic        cfg_rwn  [4];
    logic [7:0]  cfg_blk  [4];
    logic        cfg_ast  [4];

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic vec_t mk(input int cfg, input int reps, input logic [8:0] ev,
                                input logic [4:0] eo, input logic [5:0] eop,
                                input logic [31:0] earg, input logic [2:0] ersp,
                                input logic [3:0] est);
        vec_t v;
        v.cfg  = cfg;
        v.reps = reps;
        v.ev   = ev;
        v.eo   = eo;
        v.eop  = eop;
        v.earg = earg;
        v.ersp = ersp;
        v.est  = est;
        return v;
    endfunction

    task automatic drive_cfg(input int c);
        cmd_op_i         = cfg_op[c];
        cmd_arg_i        = cfg_arg[c];
        cmd_rsp_type_i   = cfg_rsp[c];
        data_en_i        = cfg_den[c];
        data_rwn_i       = cfg_rwn[c];
        data_block_num_i = cfg_blk[c];
        auto_stop_en_i   = cfg_ast[c];
    endtask

    task automatic apply(input vec_t v);
        drive_cfg(v.cfg);
        cmd_start_i        = v.ev[8];
        eng_if.cmd_eot     = v.ev[7];
        eng_if.cmd_err     = v.ev[6];
        eng_if.start_read  = v.ev[5];
        eng_if.start_write = v.ev[4];
        eng_if.data_last   = v.ev[3];
        eng_if.data_eot    = v.ev[2];
        eng_if.data_err    = v.ev[1];
        clr_stat_i         = v.ev[0];
    endtask

    task automatic compare(input string tag, input vec_t v);
        check({tag, " cmd_start_o"},  32'(eng_if.cmd_start),    32'(v.eo[4]));
        check({tag, " data_start_o"}, 32'(eng_if.data_start),   32'(v.eo[3]));
        check({tag, " data_abort_o"}, 32'(eng_if.data_abort),   32'(v.eo[2]));
        check({tag, " busy_o"},       32'(busy_o),              32'(v.eo[1]));
        check({tag, " eot_o"},        32'(eot_o),               32'(v.eo[0]));
        check({tag, " cmd_op_o"},     32'(eng_if.cmd_op),       32'(v.eop));
        check({tag, " cmd_arg_o"},    eng_if.cmd_arg,           v.earg);
        check({tag, " cmd_rsp_o"},    32'(eng_if.cmd_rsp_type), 32'(v.ersp));
        check({tag, " status_o"},     32'(status_o),            32'(v.est));
    endtask

    task automatic idle_inputs();
        cmd_start_i        = 1'b0;
        clr_stat_i         = 1'b0;
        eng_if.cmd_eot     = 1'b0;
        eng_if.cmd_err     = 1'b0;
        eng_if.start_read  = 1'b0;
        eng_if.start_write = 1'b0;
        eng_if.data_last   = 1'b0;
        eng_if.data_eot    = 1'b0;
        eng_if.data_err    = 1'b0;
    endtask

    initial begin
        // cfg0: command only; cfg1: single-block read; cfg2: 4-block write; cfg3: 4-block read
        cfg_op[0] = 6'd8;  cfg_arg[0] = 32'h1AA;  cfg_rsp[0] = 3'd2; cfg_den[0] = 1'b0;
        cfg_rwn[0] = 1'b0; cfg_blk[0] = 8'd0;     cfg_ast[0] = 1'b0;
        cfg_op[1] = 6'd17; cfg_arg[1] = 32'h100;  cfg_rsp[1] = 3'd1; cfg_den[1] = 1'b1;
        cfg_rwn[1] = 1'b1; cfg_blk[1] = 8'd0;     cfg_ast[1] = 1'b1;
        cfg_op[2] = 6'd25; cfg_arg[2] = 32'h2000; cfg_rsp[2] = 3'd5; cfg_den[2] = 1'b1;
        cfg_rwn[2] = 1'b0; cfg_blk[2] = 8'd3;     cfg_ast[2] = 1'b1;
        cfg_op[3] = 6'd18; cfg_arg[3] = 32'h40;   cfg_rsp[3] = 3'd1; cfg_den[3] = 1'b1;
        cfg_rwn[3] = 1'b1; cfg_blk[3] = 8'd3;     cfg_ast[3] = 1'b1;

        // Single command, no data; a second start mid-RUN must be ignored.
        tbl.push_back(mk(0, 1, EV_CS,   5'h0,         6'd0, 32'h0,   3'd0, 4'h0));
        tbl.push_back(mk(0, 1, 9'h0,    O_CS | O_BSY, 6'd8, 32'h1AA, 3'd2, 4'h0));
        tbl.push_back(mk(0, 3, 9'h0,    O_BSY,        6'd8, 32'h1AA, 3'd2, 4'h0));
        tbl.push_back(mk(3, 1, EV_CS,   O_BSY,        6'd8, 32'h1AA, 3'd2, 4'h0));
        tbl.push_back(mk(0, 4, 9'h0,    O_BSY,        6'd8, 32'h1AA, 3'd2, 4'h0));
        tbl.push_back(mk(0, 1, EV_CEOT, O_BSY,        6'd8, 32'h1AA, 3'd2, 4'h0));
        tbl.push_back(mk(0, 1, 9'h0,    O_BSY | O_EOT, 6'd8, 32'h1AA, 3'd2, 4'h0));
        tbl.push_back(mk(0, 1, 9'h0,    5'h0,         6'd8, 32'h1AA, 3'd2, 4'h0));
        // Single-block read: wrong-direction trigger ignored, one data start, no CMD12.
        tbl.push_back(mk(1, 1, EV_CS,   5'h0,          6'd8,  32'h1AA, 3'd2, 4'h0));
        tbl.push_back(mk(1, 1, 9'h0,    O_CS | O_BSY,  6'd17, 32'h100, 3'd1, 4'h0));
        tbl.push_back(mk(1, 1, EV_CEOT, O_BSY,         6'd17, 32'h100, 3'd1, 4'h0));
        tbl.push_back(mk(1, 1, EV_SWR,  O_BSY,         6'd17, 32'h100, 3'd1, 4'h0));
        tbl.push_back(mk(1, 1, EV_SRD,  O_DS | O_BSY,  6'd17, 32'h100, 3'd1, 4'h0));
        tbl.push_back(mk(1, 1, EV_SRD,  O_BSY,         6'd17, 32'h100, 3'd1, 4'h0));
        tbl.push_back(mk(1, 2, 9'h0,    O_BSY,         6'd17, 32'h100, 3'd1, 4'h0));
        tbl.push_back(mk(1, 1, EV_DEOT, O_BSY,         6'd17, 32'h100, 3'd1, 4'h0));
        tbl.push_back(mk(1, 1, 9'h0,    O_BSY | O_EOT, 6'd17, 32'h100, 3'd1, 4'h0));
        tbl.push_back(mk(1, 1, 9'h0,    5'h0,          6'd17, 32'h100, 3'd1, 4'h0));
        // Multi-block write: data_last before cmd_eot defers the stop.
        tbl.push_back(mk(2, 1, EV_CS,    5'h0,          6'd17, 32'h100,  3'd1, 4'h0));
        tbl.push_back(mk(2, 1, 9'h0,     O_CS | O_BSY,  6'd25, 32'h2000, 3'd5, 4'h0));
        tbl.push_back(mk(2, 1, EV_SWR,   O_DS | O_BSY,  6'd25, 32'h2000, 3'd5, 4'h0));
        tbl.push_back(mk(2, 1, EV_DLAST, O_BSY,         6'd25, 32'h2000, 3'd5, 4'h0));
        tbl.push_back(mk(2, 2, 9'h0,     O_BSY,         6'd25, 32'h2000, 3'd5, 4'h0));
        tbl.push_back(mk(2, 1, EV_CEOT,  O_BSY,         6'd25, 32'h2000, 3'd5, 4'h0));
        tbl.push_back(mk(2, 1, 9'h0,     O_CS | O_BSY,  6'd12, 32'h0,    3'd1, 4'h0));
        tbl.push_back(mk(2, 1, EV_DEOT,  O_BSY,         6'd12, 32'h0,    3'd1, 4'h0));
        tbl.push_back(mk(2, 2, 9'h0,     O_BSY,         6'd12, 32'h0,    3'd1, 4'h0));
        tbl.push_back(mk(2, 1, EV_CEOT,  O_BSY,         6'd12, 32'h0,    3'd1, 4'h0));
        tbl.push_back(mk(2, 1, 9'h0,     O_BSY | O_EOT, 6'd12, 32'h0,    3'd1, 4'h0));
        tbl.push_back(mk(2, 1, 9'h0,     5'h0,          6'd12, 32'h0,    3'd1, 4'h0));
        // Multi-block write: immediate stop, then stop eot and data eot in one cycle.
        tbl.push_back(mk(2, 1, EV_CS,             5'h0,          6'd12, 32'h0,    3'd1, 4'h0));
        tbl.push_back(mk(2, 1, 9'h0,              O_CS | O_BSY,  6'd25, 32'h2000, 3'd5, 4'h0));
        tbl.push_back(mk(2, 1, EV_CEOT,           O_BSY,         6'd25, 32'h2000, 3'd5, 4'h0));
        tbl.push_back(mk(2, 1, EV_SWR,            O_DS | O_BSY,  6'd25, 32'h2000, 3'd5, 4'h0));
        tbl.push_back(mk(2, 1, EV_DLAST,          O_BSY,         6'd25, 32'h2000, 3'd5, 4'h0));
        tbl.push_back(mk(2, 1, 9'h0,              O_CS | O_BSY,  6'd12, 32'h0,    3'd1, 4'h0));
        tbl.push_back(mk(2, 1, EV_CEOT | EV_DEOT, O_BSY,         6'd12, 32'h0,    3'd1, 4'h0));
        tbl.push_back(mk(2, 1, 9'h0,              O_BSY | O_EOT, 6'd12, 32'h0,    3'd1, 4'h0));
        tbl.push_back(mk(2, 1, 9'h0,              5'h0,          6'd12, 32'h0,    3'd1, 4'h0));
        // Command error after data started: abort, status 0001, then clear.
        tbl.push_back(mk(3, 1, EV_CS,             5'h0,                  6'd12, 32'h0,  3'd1, 4'h0));
        tbl.push_back(mk(3, 1, 9'h0,              O_CS | O_BSY,          6'd18, 32'h40, 3'd1, 4'h0));
        tbl.push_back(mk(3, 1, EV_SRD,            O_DS | O_BSY,          6'd18, 32'h40, 3'd1, 4'h0));
        tbl.push_back(mk(3, 1, EV_CEOT | EV_CERR, O_BSY,                 6'd18, 32'h40, 3'd1, 4'h0));
        tbl.push_back(mk(3, 1, 9'h0,              O_BSY | O_EOT | O_AB,  6'd18, 32'h40, 3'd1, 4'h1));
        tbl.push_back(mk(3, 1, 9'h0,              5'h0,                  6'd18, 32'h40, 3'd1, 4'h1));
        tbl.push_back(mk(3, 1, EV_CLR,            5'h0,                  6'd18, 32'h40, 3'd1, 4'h1));
        tbl.push_back(mk(3, 1, 9'h0,              5'h0,                  6'd18, 32'h40, 3'd1, 4'h0));
        // Data error together with a clear: the set wins.
        tbl.push_back(mk(1, 1, EV_CS,  5'h0,          6'd18, 32'h40,  3'd1, 4'h0));
        tbl.push_back(mk(1, 1, 9'h0,   O_CS | O_BSY,  6'd17, 32'h100, 3'd1, 4'h0));
        tbl.push_back(mk(1, 1, EV_SRD, O_DS | O_BSY,  6'd17, 32'h100, 3'd1, 4'h0));
        tbl.push_back(mk(1, 1, EV_DEOT | EV_DERR | EV_CLR, O_BSY, 6'd17, 32'h100, 3'd1, 4'h0));
        tbl.push_back(mk(1, 1, 9'h0,   O_BSY | O_EOT, 6'd17, 32'h100, 3'd1, 4'h4));
        tbl.push_back(mk(1, 1, EV_CLR, 5'h0,          6'd17, 32'h100, 3'd1, 4'h4));
        tbl.push_back(mk(1, 1, 9'h0,   5'h0,          6'd17, 32'h100, 3'd1, 4'h0));
`ifdef SDIO_SEQ_TIMEOUT_EN
        // timeout_i = 20 with no progress: counter reaches 20 in the 21st RUN cycle.
        tbl.push_back(mk(1, 1,  EV_CS,  5'h0,                  6'd17, 32'h100, 3'd1, 4'h0));
        tbl.push_back(mk(1, 1,  9'h0,   O_CS | O_BSY,          6'd17, 32'h100, 3'd1, 4'h0));
        tbl.push_back(mk(1, 21, 9'h0,   O_BSY,                 6'd17, 32'h100, 3'd1, 4'h0));
        tbl.push_back(mk(1, 1,  9'h0,   O_BSY | O_EOT | O_AB,  6'd17, 32'h100, 3'd1, 4'h8));
        tbl.push_back(mk(1, 1,  EV_CLR, 5'h0,                  6'd17, 32'h100, 3'd1, 4'h8));
        tbl.push_back(mk(1, 1,  9'h0,   5'h0,                  6'd17, 32'h100, 3'd1, 4'h0));
`else
        // Timeout disabled: a long quiet RUN neither aborts nor sets status[3].
        tbl.push_back(mk(0, 1,  EV_CS,   5'h0,          6'd17, 32'h100, 3'd1, 4'h0));
        tbl.push_back(mk(0, 1,  9'h0,    O_CS | O_BSY,  6'd8,  32'h1AA, 3'd2, 4'h0));
        tbl.push_back(mk(0, 30, 9'h0,    O_BSY,         6'd8,  32'h1AA, 3'd2, 4'h0));
        tbl.push_back(mk(0, 1,  EV_CEOT, O_BSY,         6'd8,  32'h1AA, 3'd2, 4'h0));
        tbl.push_back(mk(0, 1,  9'h0,    O_BSY | O_EOT, 6'd8,  32'h1AA, 3'd2, 4'h0));
        tbl.push_back(mk(0, 1,  9'h0,    5'h0,          6'd8,  32'h1AA, 3'd2, 4'h0));
`endif

        rstn_i    = 1'b0;
        timeout_i = TIMEOUT_W'(20);
        idle_inputs();
        drive_cfg(0);
        repeat (2) tick();
        check("reset busy_o", 32'(busy_o), 32'd0);
        check("reset eot_o", 32'(eot_o), 32'd0);
        check("reset status_o", 32'(status_o), 32'd0);
        check("reset cmd_start_o", 32'(eng_if.cmd_start), 32'd0);
        check("reset cmd_op_o", 32'(eng_if.cmd_op), 32'd0);
        check("reset data_abort_o", 32'(eng_if.data_abort), 32'd0);
        rstn_i = 1'b1;

        for (int r = 0; r < tbl.size(); r++) begin
            for (int k = 0; k < tbl[r].reps; k++) begin
                apply(tbl[r]);
                #1;
                compare($sformatf("row%0d.c%0d", r, k), tbl[r]);
                tick();
            end
        end
        idle_inputs();

        // Reset in the middle of a multi-block write.
        drive_cfg(2);
        cmd_start_i = 1'b1;
        tick();
        cmd_start_i = 1'b0;
        repeat (2) tick();
        check("mid busy before reset", 32'(busy_o), 32'd1);
        eng_if.start_write = 1'b1;
        #1;
        check("mid data_start before reset", 32'(eng_if.data_start), 32'd1);
        #1;
        rstn_i = 1'b0;
        #1;
        check("mid rst busy_o", 32'(busy_o), 32'd0);
        check("mid rst cmd_op_o", 32'(eng_if.cmd_op), 32'd0);
        check("mid rst cmd_arg_o", eng_if.cmd_arg, 32'd0);
        check("mid rst cmd_rsp_o", 32'(eng_if.cmd_rsp_type), 32'd0);
        check("mid rst data_start_o", 32'(eng_if.data_start), 32'd0);
        check("mid rst status_o", 32'(status_o), 32'd0);
        eng_if.start_write = 1'b0;
        tick();
        rstn_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("post rst c%0d eot_o", k), 32'(eot_o), 32'd0);
            check($sformatf("post rst c%0d busy_o", k), 32'(busy_o), 32'd0);
        end
        drive_cfg(0);
        cmd_start_i = 1'b1;
        tick();
        cmd_start_i = 1'b0;
        check("restart cmd_start_o", 32'(eng_if.cmd_start), 32'd1);
        check("restart cmd_op_o", 32'(eng_if.cmd_op), 32'd8);
        check("restart busy_o", 32'(busy_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
